ifu_lsu_arbiter: RTL and testbench
==================================

IFU_LSU_ARBITER -- requirements
Module: ifu_lsu_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, address width of all address ports.
REQ-002 Parameter DATA_W, default 32, data width; mask width is DATA_W/8.
REQ-003 clk_i  input  1  single clock; all state on rising edge.
REQ-004 rst_i  input  1  reset, asynchronous, active-high.
REQ-005 ifu_req_i  input  1  IFU read request; held high until ifu_gnt_o.
REQ-006 ifu_gnt_o  output  1  one-cycle pulse: IFU request accepted and fields captured.
REQ-007 ifu_addr_i  input  ADDR_W  IFU fetch address.
REQ-008 lsu_req_i  input  1  LSU request; held high until lsu_gnt_o.
REQ-009 lsu_gnt_o  output  1  one-cycle pulse: LSU request accepted and fields captured.
REQ-010 lsu_addr_i  input  ADDR_W  LSU address.
REQ-011 lsu_wen_i  input  1  1 = write, 0 = read.
REQ-012 lsu_wdata_i  input  DATA_W  LSU write data.
REQ-013 lsu_wmask_i  input  DATA_W/8  LSU byte-write mask.
REQ-014 ifu_rvalid_o  output  1  response for IFU valid this cycle; no back-pressure.
REQ-015 lsu_rvalid_o  output  1  response/write-ack for LSU valid this cycle; no back-pressure.
REQ-016 rdata_o  output  DATA_W  shared response data; mem_rdata_i when either rvalid is high, else 0.
REQ-017 mem_req_o  output  1  downstream request valid.
REQ-018 mem_gnt_i  input  1  downstream accepts request when mem_req_o & mem_gnt_i.
REQ-019 mem_addr_o  output  ADDR_W  registered request address.
REQ-020 mem_wen_o  output  1  registered write enable (always 0 for IFU).
REQ-021 mem_wdata_o  output  DATA_W  registered write data (0 for IFU).
REQ-022 mem_wmask_o  output  DATA_W/8  registered mask (0 for IFU).
REQ-023 mem_rvalid_i  input  1  downstream response valid (reads and write-acks).
REQ-024 mem_rdata_i  input  DATA_W  downstream response data.

Function
REQ-025 FSM states IDLE, REQ, RSP; owner register (IFU/LSU); last-served register.
REQ-026 IDLE, exactly one req high: grant it; both high: grant the requester not in last-served (round-robin); neither: stay IDLE.
REQ-027 On grant: pulse that gnt_o combinationally in the same IDLE cycle, capture its addr/wen/wdata/wmask into request registers, set owner and last-served, next state REQ.
REQ-028 gnt_o never asserted outside IDLE; never both gnt_o in one cycle.
REQ-029 Request dropped before grant: no capture, no side effect.
REQ-030 REQ: mem_req_o=1 with registered fields stable; on mem_gnt_i go RSP, else hold.
REQ-031 RSP: mem_req_o=0; on mem_rvalid_i assert owner's rvalid_o combinationally that cycle, rdata_o=mem_rdata_i, next state IDLE.
REQ-032 mem_rvalid_i in IDLE or REQ ignored; no rvalid_o.
REQ-033 Single outstanding transaction; minimum turnaround grant-to-next-grant 3 cycles (IDLE, REQ with immediate gnt, RSP with immediate rvalid).
REQ-034 New requests arriving during REQ/RSP wait; arbitration re-evaluated on return to IDLE.

Reset
REQ-035 rst_i high: FSM to IDLE, owner=IFU, last-served=IFU (LSU wins first tie), request registers 0; all outputs 0 while in reset.
REQ-036 Reset mid-transaction abandons it; stray mem_rvalid_i after reset ignored per REQ-032.

Verification
REQ-037 IFU alone, addr 0x8000_0000, mem_gnt_i immediate, rdata 0x0000_0413 one cycle later -> ifu_gnt_o cycle 0, mem_req_o cycle 1 addr 0x8000_0000 wen 0, ifu_rvalid_o cycle 2 rdata_o 0x0000_0413.
REQ-038 Both request from reset -> LSU granted first; IFU granted on next IDLE; third tie -> LSU.
REQ-039 LSU write addr 0x1000, wdata 0xDEAD_BEEF, mask 0xF, mem_gnt_i delayed 3 cycles -> mem_* held stable 4 cycles, lsu_rvalid_o on ack, no ifu_rvalid_o.
REQ-040 mem_rvalid_i pulsed in IDLE and in REQ -> no rvalid_o, state unchanged.
REQ-041 rst_i asserted in RSP -> outputs 0 immediately, later mem_rvalid_i ignored, next request served normally.

Source files
------------

// File: rtl/ifu_lsu_arbiter.sv
// ifu_lsu_arbiter
//   Arbitrates a single downstream memory port between an instruction fetch
//   unit (read only) and a load/store unit (read or write). Only one
//   transaction is outstanding at a time. When both units request in the same
//   IDLE cycle, the grant alternates between them.
//
// Ports
//   clk_i, rst_i                      clock, async active-high reset
//   ifu_req_i/ifu_addr_i/ifu_gnt_o    IFU request channel
//   lsu_req_i/lsu_addr_i/lsu_wen_i/
//   lsu_wdata_i/lsu_wmask_i/lsu_gnt_o LSU request channel
//   ifu_rvalid_o, lsu_rvalid_o        per-unit response strobes
//   rdata_o                           shared response data (0 when idle)
//   mem_req_o/mem_gnt_i/mem_addr_o/
//   mem_wen_o/mem_wdata_o/mem_wmask_o downstream request (registered fields)
//   mem_rvalid_i/mem_rdata_i          downstream response
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | no transaction; arbitrate and grant one requester
// REQ   | presenting the captured request downstream, wait for mem_gnt_i
// RSP   | request accepted downstream, wait for mem_rvalid_i
module ifu_lsu_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                ifu_req_i,
    output logic                ifu_gnt_o,
    input  logic [ADDR_W-1:0]   ifu_addr_i,
    input  logic                lsu_req_i,
    output logic                lsu_gnt_o,
    input  logic [ADDR_W-1:0]   lsu_addr_i,
    input  logic                lsu_wen_i,
    input  logic [DATA_W-1:0]   lsu_wdata_i,
    input  logic [DATA_W/8-1:0] lsu_wmask_i,
    output logic                ifu_rvalid_o,
    output logic                lsu_rvalid_o,
    output logic [DATA_W-1:0]   rdata_o,
    output logic                mem_req_o,
    input  logic                mem_gnt_i,
    output logic [ADDR_W-1:0]   mem_addr_o,
    output logic                mem_wen_o,
    output logic [DATA_W-1:0]   mem_wdata_o,
    output logic [DATA_W/8-1:0] mem_wmask_o,
    input  logic                mem_rvalid_i,
    input  logic [DATA_W-1:0]   mem_rdata_i
);

    localparam int MASK_W = DATA_W / 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RSP  = 2'd2
    } state_t;

    // owner/last-served encoding: 0 = IFU, 1 = LSU
    localparam logic SEL_IFU = 1'b0;
    localparam logic SEL_LSU = 1'b1;

    state_t              state_q, state_d;
    logic                owner_q, owner_d;
    logic                last_q, last_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                wen_q, wen_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [MASK_W-1:0]   wmask_q, wmask_d;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            owner_q <= SEL_IFU;
            last_q  <= SEL_IFU;
            addr_q  <= '0;
            wen_q   <= 1'b0;
            wdata_q <= '0;
            wmask_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            addr_q  <= addr_d;
            wen_q   <= wen_d;
            wdata_q <= wdata_d;
            wmask_q <= wmask_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_d       = last_q;
        addr_d       = addr_q;
        wen_d        = wen_q;
        wdata_d      = wdata_q;
        wmask_d      = wmask_q;
        ifu_gnt_o    = 1'b0;
        lsu_gnt_o    = 1'b0;
        ifu_rvalid_o = 1'b0;
        lsu_rvalid_o = 1'b0;
        mem_req_o    = 1'b0;

        case (state_q)
            S_IDLE: begin
                // Grants are combinational from the request inputs, so they
                // must be masked explicitly while reset is held.
                if (!rst_i) begin
                    // LSU wins a tie unless it was the last one served.
                    if (lsu_req_i && (!ifu_req_i || last_q == SEL_IFU)) begin
                        lsu_gnt_o = 1'b1;
                        owner_d   = SEL_LSU;
                        last_d    = SEL_LSU;
                        addr_d    = lsu_addr_i;
                        wen_d     = lsu_wen_i;
                        wdata_d   = lsu_wdata_i;
                        wmask_d   = lsu_wmask_i;
                        state_d   = S_REQ;
                    end else if (ifu_req_i) begin
                        ifu_gnt_o = 1'b1;
                        owner_d   = SEL_IFU;
                        last_d    = SEL_IFU;
                        addr_d    = ifu_addr_i;
                        wen_d     = 1'b0;
                        wdata_d   = '0;
                        wmask_d   = '0;
                        state_d   = S_REQ;
                    end
                end
            end
            S_REQ: begin
                mem_req_o = 1'b1;
                if (mem_gnt_i) begin
                    state_d = S_RSP;
                end
            end
            S_RSP: begin
                if (mem_rvalid_i) begin
                    if (owner_q == SEL_LSU) begin
                        lsu_rvalid_o = 1'b1;
                    end else begin
                        ifu_rvalid_o = 1'b1;
                    end
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign rdata_o     = (ifu_rvalid_o || lsu_rvalid_o) ? mem_rdata_i : '0;
    assign mem_addr_o  = addr_q;
    assign mem_wen_o   = wen_q;
    assign mem_wdata_o = wdata_q;
    assign mem_wmask_o = wmask_q;

endmodule

// File: tb/tb_ifu_lsu_arbiter.sv
module tb_ifu_lsu_arbiter;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    logic              clk_i = 1'b0;
    logic              rst_i = 1'b1;
    logic              ifu_req_i = 1'b0;
    logic              ifu_gnt_o;
    logic [ADDR_W-1:0] ifu_addr_i = '0;
    logic              lsu_req_i = 1'b0;
    logic              lsu_gnt_o;
    logic [ADDR_W-1:0] lsu_addr_i = '0;
    logic              lsu_wen_i = 1'b0;
    logic [DATA_W-1:0] lsu_wdata_i = '0;
    logic [3:0]        lsu_wmask_i = '0;
    logic              ifu_rvalid_o;
    logic              lsu_rvalid_o;
    logic [DATA_W-1:0] rdata_o;
    logic              mem_req_o;
    logic              mem_gnt_i = 1'b0;
    logic [ADDR_W-1:0] mem_addr_o;
    logic              mem_wen_o;
    logic [DATA_W-1:0] mem_wdata_o;
    logic [3:0]        mem_wmask_o;
    logic              mem_rvalid_i = 1'b0;
    logic [DATA_W-1:0] mem_rdata_i = '0;

    int checks = 0;
    int errors = 0;

    ifu_lsu_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .ifu_req_i    (ifu_req_i),
        .ifu_gnt_o    (ifu_gnt_o),
        .ifu_addr_i   (ifu_addr_i),
        .lsu_req_i    (lsu_req_i),
        .lsu_gnt_o    (lsu_gnt_o),
        .lsu_addr_i   (lsu_addr_i),
        .lsu_wen_i    (lsu_wen_i),
        .lsu_wdata_i  (lsu_wdata_i),
        .lsu_wmask_i  (lsu_wmask_i),
        .ifu_rvalid_o (ifu_rvalid_o),
        .lsu_rvalid_o (lsu_rvalid_o),
        .rdata_o      (rdata_o),
        .mem_req_o    (mem_req_o),
        .mem_gnt_i    (mem_gnt_i),
        .mem_addr_o   (mem_addr_o),
        .mem_wen_o    (mem_wen_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_wmask_o  (mem_wmask_o),
        .mem_rvalid_i (mem_rvalid_i),
        .mem_rdata_i  (mem_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // advance to just after the next rising edge
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    // Called during a REQ cycle: immediate mem grant, then response next cycle.
    task automatic finish_txn(input string tag, input logic lsu_owner, input logic [31:0] d);
        mem_gnt_i = 1'b1;
        tick();
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = d;
        settle();
        chk({tag, "_ifu_rvalid"}, ifu_rvalid_o, !lsu_owner);
        chk({tag, "_lsu_rvalid"}, lsu_rvalid_o, lsu_owner);
        chk({tag, "_rdata"}, rdata_o, d);
        chk({tag, "_rsp_no_gnt"}, {ifu_gnt_o, lsu_gnt_o}, 2'b00);
        tick();
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = '0;
    endtask

    initial begin
        // ---------------- reset state
        tick();
        tick();
        settle();
        chk("rst_mem_req", mem_req_o, 1'b0);
        chk("rst_mem_addr", mem_addr_o, 32'h0);
        chk("rst_gnt", {ifu_gnt_o, lsu_gnt_o}, 2'b00);
        chk("rst_rvalid", {ifu_rvalid_o, lsu_rvalid_o}, 2'b00);
        rst_i = 1'b0;
        tick();

        // ---------------- IFU alone, basic read
        ifu_req_i  = 1'b1;
        ifu_addr_i = 32'h8000_0000;
        settle();
        chk("t1_ifu_gnt", ifu_gnt_o, 1'b1);
        chk("t1_lsu_gnt", lsu_gnt_o, 1'b0);
        tick();
        ifu_req_i  = 1'b0;
        ifu_addr_i = 32'h1111_1111;
        mem_gnt_i  = 1'b1;
        settle();
        chk("t1_mem_req", mem_req_o, 1'b1);
        chk("t1_mem_addr", mem_addr_o, 32'h8000_0000);
        chk("t1_mem_wen", mem_wen_o, 1'b0);
        chk("t1_mem_wmask", mem_wmask_o, 4'h0);
        tick();
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'h0000_0413;
        settle();
        chk("t1_ifu_rvalid", ifu_rvalid_o, 1'b1);
        chk("t1_lsu_rvalid", lsu_rvalid_o, 1'b0);
        chk("t1_rdata", rdata_o, 32'h0000_0413);
        chk("t1_rsp_mem_req", mem_req_o, 1'b0);
        tick();
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = '0;

        // ---------------- round-robin from reset
        rst_i = 1'b1;
        settle();
        rst_i = 1'b0;
        ifu_req_i  = 1'b1;
        ifu_addr_i = 32'h0000_0100;
        lsu_req_i  = 1'b1;
        lsu_addr_i = 32'h0000_0200;
        settle();
        chk("rr1_lsu_gnt", lsu_gnt_o, 1'b1);
        chk("rr1_ifu_gnt", ifu_gnt_o, 1'b0);
        tick();
        lsu_req_i = 1'b0;
        settle();
        chk("rr1_req_no_gnt", {ifu_gnt_o, lsu_gnt_o}, 2'b00);
        chk("rr1_mem_addr", mem_addr_o, 32'h0000_0200);
        finish_txn("rr1", 1'b1, 32'hAAAA_0001);
        settle();
        chk("rr2_ifu_gnt", ifu_gnt_o, 1'b1);
        chk("rr2_lsu_gnt", lsu_gnt_o, 1'b0);
        tick();
        lsu_req_i = 1'b1;      // both pending while busy
        settle();
        chk("rr2_mem_addr", mem_addr_o, 32'h0000_0100);
        chk("rr2_busy_no_gnt", {ifu_gnt_o, lsu_gnt_o}, 2'b00);
        finish_txn("rr2", 1'b0, 32'hBBBB_0002);
        settle();
        chk("rr3_lsu_gnt", lsu_gnt_o, 1'b1);
        chk("rr3_ifu_gnt", ifu_gnt_o, 1'b0);
        tick();
        lsu_req_i = 1'b0;
        ifu_req_i = 1'b0;      // IFU withdraws before being granted
        finish_txn("rr3", 1'b1, 32'hCCCC_0003);
        settle();
        chk("rr3_idle_no_gnt", {ifu_gnt_o, lsu_gnt_o}, 2'b00);

        // ---------------- LSU write, delayed mem grant
        lsu_req_i   = 1'b1;
        lsu_addr_i  = 32'h0000_1000;
        lsu_wen_i   = 1'b1;
        lsu_wdata_i = 32'hDEAD_BEEF;
        lsu_wmask_i = 4'hF;
        settle();
        chk("wr_lsu_gnt", lsu_gnt_o, 1'b1);
        tick();
        lsu_req_i   = 1'b0;
        lsu_addr_i  = 32'h5555_5555;
        lsu_wen_i   = 1'b0;
        lsu_wdata_i = 32'h0;
        lsu_wmask_i = 4'h3;
        for (int i = 0; i < 4; i++) begin
            mem_gnt_i = (i == 3);
            settle();
            chk("wr_mem_req", mem_req_o, 1'b1);
            chk("wr_mem_addr", mem_addr_o, 32'h0000_1000);
            chk("wr_mem_wen", mem_wen_o, 1'b1);
            chk("wr_mem_wdata", mem_wdata_o, 32'hDEAD_BEEF);
            chk("wr_mem_wmask", mem_wmask_o, 4'hF);
            tick();
        end
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b1;
        settle();
        chk("wr_lsu_rvalid", lsu_rvalid_o, 1'b1);
        chk("wr_ifu_rvalid", ifu_rvalid_o, 1'b0);
        tick();
        mem_rvalid_i = 1'b0;

        // ---------------- stray mem_rvalid_i in IDLE and REQ
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'h9999_9999;
        settle();
        chk("st_idle_rvalid", {ifu_rvalid_o, lsu_rvalid_o}, 2'b00);
        chk("st_idle_rdata", rdata_o, 32'h0);
        tick();
        mem_rvalid_i = 1'b0;
        settle();
        chk("st_idle_mem_req", mem_req_o, 1'b0);
        ifu_req_i  = 1'b1;
        ifu_addr_i = 32'h0000_0044;
        settle();
        chk("st_ifu_gnt", ifu_gnt_o, 1'b1);
        tick();
        ifu_req_i    = 1'b0;
        mem_rvalid_i = 1'b1;
        settle();
        chk("st_req_rvalid", {ifu_rvalid_o, lsu_rvalid_o}, 2'b00);
        tick();
        mem_rvalid_i = 1'b0;
        settle();
        chk("st_req_held", mem_req_o, 1'b1);
        mem_gnt_i = 1'b1;
        tick();
        mem_gnt_i = 1'b0;
        settle();
        chk("rs_rsp_mem_req", mem_req_o, 1'b0);

        // ---------------- reset during RSP
        mem_rvalid_i = 1'b1;
        ifu_req_i    = 1'b1;
        rst_i        = 1'b1;
        settle();
        chk("rs_rvalid", {ifu_rvalid_o, lsu_rvalid_o}, 2'b00);
        chk("rs_gnt", {ifu_gnt_o, lsu_gnt_o}, 2'b00);
        chk("rs_mem_addr", mem_addr_o, 32'h0);
        chk("rs_rdata", rdata_o, 32'h0);
        tick();
        rst_i     = 1'b0;
        ifu_req_i = 1'b0;
        settle();
        chk("rs_after_rvalid", {ifu_rvalid_o, lsu_rvalid_o}, 2'b00);
        tick();
        mem_rvalid_i = 1'b0;
        lsu_req_i    = 1'b1;
        lsu_addr_i   = 32'h0000_2000;
        lsu_wen_i    = 1'b0;
        lsu_wdata_i  = 32'h0;
        lsu_wmask_i  = 4'h0;
        settle();
        chk("rs_lsu_gnt", lsu_gnt_o, 1'b1);
        tick();
        lsu_req_i = 1'b0;
        settle();
        chk("rs_mem_req", mem_req_o, 1'b1);
        chk("rs_mem_addr2", mem_addr_o, 32'h0000_2000);
        chk("rs_mem_wen", mem_wen_o, 1'b0);
        finish_txn("rs", 1'b1, 32'h1234_5678);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
